// File: rtl/freq_cal.sv
// Gate-length meter: counts prescaled clock ticks while en is high, saturating at 63.
// The result holds after en falls and clears only at the next gate start or on reset.
module freq_cal #(
  parameter int DIV = 4
) (
  input  logic       en,
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] q
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic          en_dly_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    cnt_q, cnt_d;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!en) begin
      pre_d = '0;
    end else if (!en_dly_q) begin
      // Rising gate: drop the previous result and restart the prescaler.
      pre_d = '0;
      cnt_d = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_dly_q <= 1'b0;
      pre_q    <= '0;
      cnt_q    <= '0;
    end else begin
      en_dly_q <= en;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: tb/tb_freq_cal.sv
// Randomized bench for freq_cal: a DIV=4 and a DIV=2 instance share en/reset and are
// compared against a gate-length model, q = min(63, floor((N-1)/DIV)) for the latest gate.
module tb_freq_cal;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [5:0] q4, q2;

  int checks = 0;
  int failures = 0;
  int run_n = 0;
  logic prev_en = 1'b0;

  freq_cal #(.DIV(4)) u_div4 (.en(en), .clk(clk), .reset(reset), .q(q4));
  freq_cal #(.DIV(2)) u_div2 (.en(en), .clk(clk), .reset(reset), .q(q2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_q(input int n, input int div);
    int v;
    if (n == 0) return 0;
    v = (n - 1) / div;
    return (v > 63) ? 63 : v;
  endfunction

  // One clock: drive en, advance the model at the rising edge, check at the falling edge.
  task automatic cyc(input logic e, input string tag);
    en = e;
    @(posedge clk);
    if (reset) begin
      run_n = 0;
      prev_en = 1'b0;
    end else begin
      if (en) run_n = prev_en ? run_n + 1 : 1;
      prev_en = en;
    end
    @(negedge clk);
    chk({tag, "_d4"}, int'(q4), exp_q(run_n, 4));
    chk({tag, "_d2"}, int'(q2), exp_q(run_n, 2));
  endtask

  task automatic gate(input int len, input string tag);
    for (int i = 0; i < len; i++) cyc(1'b1, tag);
  endtask

  task automatic idle(input int len, input string tag);
    for (int i = 0; i < len; i++) cyc(1'b0, tag);
  endtask

  // Assert reset between edges, verify it acts before any clock, hold, release at a negedge.
  task automatic async_reset(input int hold, input logic e, input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_async_d4"}, int'(q4), 0);
    chk({tag, "_async_d2"}, int'(q2), 0);
    for (int i = 0; i < hold; i++) cyc(e, tag);
    reset = 1'b0;
  endtask

  initial begin
    // Reset held 5 cycles with en low.
    for (int i = 0; i < 5; i++) cyc(1'b0, "rst_hold");
    reset = 1'b0;
    idle(3, "post_rst");

    // Nominal gate, 250 cycles.
    gate(250, "nominal");
    idle(10, "nominal_hold");
    chk("nominal_final", int'(q4), 62);

    // Saturation.
    gate(300, "sat");
    chk("sat_final", int'(q4), 63);
    idle(2, "sat_hold");

    // Re-measure.
    gate(40, "gate40");
    idle(3, "gap");
    chk("remeasure_first", int'(q4), 9);
    cyc(1'b1, "regate_start");
    chk("regate_clear", int'(q4), 0);
    gate(8, "gate9");
    idle(2, "gate9_hold");
    chk("remeasure_final", int'(q4), 2);

    // Reset mid-gate at q=20, en stays high through release.
    gate(81, "pre_reset");
    chk("mid_gate_q20", int'(q4), 20);
    async_reset(2, 1'b1, "midrst");
    gate(5, "after_rst");
    chk("after_rst_q1", int'(q4), 1);
    idle(2, "after_rst_idle");

    // Short pulses.
    gate(1, "p1");
    idle(2, "p1_idle");
    chk("pulse1_d4", int'(q4), 0);
    chk("pulse1_d2", int'(q2), 0);
    gate(2, "p2");
    idle(2, "p2_idle");
    chk("pulse2_d2", int'(q2), 0);
    gate(3, "p3");
    idle(2, "p3_idle");
    chk("pulse3_d2", int'(q2), 1);

    // Re-assert one cycle after drop.
    gate(12, "rearm_a");
    cyc(1'b0, "rearm_gap");
    gate(6, "rearm_b");

    // Random gates with occasional reset.
    for (int k = 0; k < 200; k++) begin
      int len;
      len = (k % 10 == 0) ? $urandom_range(200, 300) : $urandom_range(1, 30);
      gate(len, "rnd_gate");
      if ($urandom_range(0, 19) == 0) async_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)), "rnd_rst");
      idle($urandom_range(0, 4), "rnd_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_cal.md
FREQ_CAL -- requirements
Module: freq_cal

Interface
REQ-001 Parameter: DIV, 4, prescaler ratio; clock cycles per q increment; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  measurement gate; synchronous to clk, sampled on the rising edge.
REQ-005 Port: q  output  6  measured gate length in prescaled ticks; registered.
REQ-006 Port declaration order SHALL be en, clk, reset, q, so that positional instantiation freq_cal(en, clk, reset, q) connects correctly.

Function
REQ-007 Internal state SHALL be:
- en_d: 1-bit registered copy of en.
- pre: prescaler, ceil(log2(DIV)) bits.
- q: 6-bit result register.
REQ-008 Gate-start cycle (en=1, en_d=0) SHALL set q<=0 and pre<=0, discarding the previous result.
REQ-009 Counting cycle (en=1, en_d=1) with pre!=DIV-1 SHALL set pre<=pre+1; q holds.
REQ-010 Counting cycle with pre==DIV-1 SHALL set pre<=0 and q<=q+1.
REQ-011 q SHALL saturate at 63:
- An increment attempted at q==63 leaves q at 63.
- q never wraps to 0.
REQ-012 Idle cycle (en=0) SHALL set pre<=0 and hold q, so the last measurement stays visible until the next gate start.
REQ-013 en_d<=en SHALL be updated every cycle, outside reset.
REQ-014 Latency: first increment of q SHALL occur on the DIV-th counting cycle after the gate-start cycle. For a gate of N consecutive en=1 sampled cycles, the final q SHALL be min(63, floor((N-1)/DIV)).
REQ-015 en falling SHALL immediately stop counting:
- A partial prescaler count is discarded.
- q is not rounded.
REQ-016 en pulse of exactly one cycle SHALL leave q=0.
REQ-017 en re-asserted one cycle after deassertion SHALL be treated as a new gate start (REQ-008).
REQ-018 en unknown/undriven before first assertion SHALL be tolerated: when reset is applied, q=0 until en is driven high.

Reset
REQ-019 reset=1 SHALL asynchronously force q=0, pre=0, en_d=0, regardless of clk or en.
REQ-020 Reset asserted mid-gate SHALL abort the measurement.
REQ-021 After reset release with en already 1:
- The first sampled cycle SHALL be a gate-start cycle, since en_d=0.
- Counting then begins per REQ-008..REQ-010.
REQ-022 Deassertion of reset SHALL take effect at the next rising clk edge with no extra latency cycles.

Verification
REQ-023 Reset held 5 cycles, en=0 -> q=0 throughout and after release.
REQ-024 Nominal gate, DIV=4, 250 sampled en=1 cycles then en=0 -> q steps every 4 cycles; final q=62, held while en=0.
REQ-025 Saturation, en=1 for 300 cycles -> q reaches 63 at cycle 253 and stays 63; never 0.
REQ-026 Re-measure: 40-cycle gate, 3 idle cycles, 9-cycle gate -> q=9, held; then q=0 on the second gate start; final q=2.
REQ-027 Reset mid-gate at q=20 -> q=0 asynchronously (before next clk edge); with en still 1 after release, a new gate starts and q=1 after 5 sampled cycles.
REQ-028 One-cycle en pulse -> q=0; two-cycle pulse with DIV=2 -> q=0; three-cycle pulse with DIV=2 -> q=1.
